decode_stage: RTL
=================

Name: decode_stage

Overview:
- Issue-side partner of the R-type ALU: accepts a 32-bit RV32 instruction and produces the ALU control fields {funct7, funct3, opcode[6:2]}, both operands and the destination register, one cycle later.
- Contains the 32x32 integer register file, with one write-back port driven from the ALU result path.
- Valid/ready on both sides. One-entry registered output stage.

Parameters:
- XLEN, 32, operand/register width
- NREGS, 32, register count (x0 hardwired zero)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction word
- out_valid  out  1  decoded bundle present
- out_ready  in  1  ALU side accepts bundle
- out_opcode  out  5  instr[6:2] or rewritten value
- out_funct3  out  3  ALU funct3
- out_funct7  out  7  ALU funct7
- out_in1  out  XLEN  rs1 value
- out_in2  out  XLEN  rs2 value or immediate
- out_rd  out  5  destination register
- out_illegal  out  1  instruction not supported
- wb_en  in  1  register write enable
- wb_rd  in  5  write index
- wb_data  in  XLEN  write data

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0; all out_* fields=0.
  - All registers cleared to 0.
  - Any held bundle is dropped, and wb writes in that cycle are ignored.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The bundle is registered and out_valid=1 on the next cycle; latency 1.
  - Output fields hold stable while out_valid && !out_ready.
  - out_valid clears when out_ready is high and no new accept occurs. Back-to-back accepts give full throughput.
- Decode:
  - instr[1:0] must be 2'b11, otherwise illegal.
  - opcode=instr[6:2], rd=instr[11:7], funct3=instr[14:12], rs1=instr[19:15], rs2=instr[24:20], funct7=instr[31:25].
- Legal R-type: opcode 01100 with either
  - funct7=0000000 (any funct3), or
  - funct7=0100000 and funct3 is 000 or 101.
- Illegal bundle: out_illegal=1; opcode/funct3/funct7/in1/in2/rd are forced to 0, so the ALU produces 0 and no register is written. It still passes through the handshake.
- Register read is combinational at accept time.
  - Index 0 reads 0.
  - Bypass: if wb_en && wb_rd==rs && rs!=0 in the accept cycle, wb_data is used instead of the array value.
- Write-back: on posedge, if wb_en && wb_rd!=0, then reg[wb_rd] <= wb_data. Writes to x0 are discarded. Writes are independent of the handshake.

Optional Feature:
- Macro: DECODE_ITYPE_EN.
- When defined, OP-IMM (opcode 00100) is rewritten as R-type for the ALU:
  - out_opcode=01100, funct3 passed through.
  - in2 = sign-extended instr[31:20].
  - funct7 = 0000000, except funct3=101 with instr[31:25]=0100000 (SRAI), which gives 0100000.
  - Shifts (funct3 001/101) use in2 = zero-extended instr[24:20]; instr[31:25] other than 0000000 (or 0100000 for 101) is illegal.
- When undefined, opcode 00100 is illegal.

Decomposition:
- Shared package holds:
  - opcode constants (OPC_OP=5'b01100, OPC_OPIMM=5'b00100)
  - funct7 constants (F7_BASE, F7_ALT)
  - funct3 constants for each ALU operation
  - the decoded-bundle struct type
- One sub-module: regfile (2 async read ports, 1 sync write port, synchronous clear, x0 zero, internal bypass).

Test Plan:
- After reset, write x1=5 and x2=3 via wb; issue 0x002081B3 (add x3,x1,x2) -> one cycle later out_valid=1, opcode=01100, funct3=000, funct7=0, in1=5, in2=3, rd=3, illegal=0.
- Issue 0x407352B3 (sra x5,x6,x7) with x6=0x80000000, x7=4 -> funct7=0100000, funct3=101, in1=0x80000000, in2=4, rd=5.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle stable, second instruction accepted only once out_ready=1. Then stream 4 instructions with out_ready=1 -> one bundle per cycle.
- Issue add x3,x1,x2 in the same cycle as wb_en=1, wb_rd=1, wb_data=0xDEADBEEF -> in1=0xDEADBEEF. With wb_rd=0 -> x0 still reads 0.
- Issue 0x00000000, then 0x422081B3 (funct7=0100001) -> out_illegal=1 with all fields 0.
- DECODE_ITYPE_EN: 0xFFF00093 (addi x1,x0,-1) -> opcode=01100, funct7=0, in1=0, in2=0xFFFFFFFF, rd=1. Without the macro, the same word gives illegal=1.
- Assert rst while out_valid=1 -> next cycle out_valid=0 and all registers read 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode constants and the registered control bundle for decode_stage.
package decode_stage_pkg;

  localparam logic [4:0] OPC_OP    = 5'b01100;
  localparam logic [4:0] OPC_OPIMM = 5'b00100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       illegal;
  } dec_ctrl_t;

  // Only SUB and SRA use the alternate funct7 encoding.
  function automatic logic op_legal(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADDSUB) || (f3 == F3_SR)));
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Issue-side bus of decode_stage: instruction in, decoded bundle out, ALU write-back.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_in1;
  logic [XLEN-1:0] out_in2;
  logic [4:0]      out_rd;
  logic            out_illegal;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_opcode, out_funct3, out_funct7,
           out_in1, out_in2, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_opcode, out_funct3, out_funct7,
           out_in1, out_in2, out_rd, out_illegal
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// Integer register file: two async read ports with write-through bypass, one sync write port.
module decode_stage_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_wb_en && (i_wb_rd != 5'd0)) begin
      r_mem[i_wb_rd] <= i_wb_data;
    end
  end

  // Same-cycle write is forwarded so a dependent instruction sees it without a stall.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != 5'd0) o_rd1 = (i_wb_en && (i_wb_rd == i_ra1)) ? i_wb_data : r_mem[i_ra1];
    if (i_ra2 != 5'd0) o_rd2 = (i_wb_en && (i_wb_rd == i_ra2)) ? i_wb_data : r_mem[i_ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage feeding the R-type ALU; one registered output slot.
// Optional OP-IMM to R-type rewrite enabled by DECODE_ITYPE_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  logic [31:0]     w_instr;
  logic [4:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1, w_rs2;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic            w_in_ready, w_accept, w_ok;
  logic [6:0]      w_f7_out;
  logic [XLEN-1:0] w_in2_raw, w_in1, w_in2;
  dec_ctrl_t       w_ctrl;

  logic            r_valid;
  dec_ctrl_t       r_ctrl;
  logic [XLEN-1:0] r_in1, r_in2;

  assign w_instr = bus.in_instr;
  assign w_opc   = w_instr[6:2];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];

  decode_stage_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_wb_en   (bus.wb_en),
    .i_wb_rd   (bus.wb_rd),
    .i_wb_data (bus.wb_data),
    .i_ra1     (w_rs1),
    .i_ra2     (w_rs2),
    .o_rd1     (w_rs1_val),
    .o_rd2     (w_rs2_val)
  );

  always_comb begin
    w_ok      = 1'b0;
    w_f7_out  = w_f7;
    w_in2_raw = w_rs2_val;
    w_ctrl    = '0;
    w_in1     = '0;
    w_in2     = '0;
    if (w_instr[1:0] == 2'b11) begin
      if (w_opc == OPC_OP) begin
        w_ok = op_legal(w_f7, w_f3);
      end
`ifdef DECODE_ITYPE_EN
      else if (w_opc == OPC_OPIMM) begin
        w_f7_out  = F7_BASE;
        w_in2_raw = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
        case (w_f3)
          F3_SLL: begin
            w_ok      = (w_f7 == F7_BASE);
            w_in2_raw = XLEN'(w_instr[24:20]);
          end
          F3_SR: begin
            w_ok      = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            w_f7_out  = w_f7;
            w_in2_raw = XLEN'(w_instr[24:20]);
          end
          default: w_ok = 1'b1;
        endcase
      end
`endif
    end
    // Illegal bundles carry all-zero fields so the ALU yields 0 into x0.
    if (w_ok) begin
      w_ctrl.opcode = OPC_OP;
      w_ctrl.funct3 = w_f3;
      w_ctrl.funct7 = w_f7_out;
      w_ctrl.rd     = w_instr[11:7];
      w_in1         = w_rs1_val;
      w_in2         = w_in2_raw;
    end else begin
      w_ctrl.illegal = 1'b1;
    end
  end

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl;
      r_in1   <= w_in1;
      r_in2   <= w_in2;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_valid;
  assign bus.out_opcode  = r_ctrl.opcode;
  assign bus.out_funct3  = r_ctrl.funct3;
  assign bus.out_funct7  = r_ctrl.funct7;
  assign bus.out_rd      = r_ctrl.rd;
  assign bus.out_illegal = r_ctrl.illegal;
  assign bus.out_in1     = r_in1;
  assign bus.out_in2     = r_in2;

endmodule
